// File: rtl/character_anim_ctrl_if.sv
// rtl/character_anim_ctrl_if.sv - physics/timing to sprite-stage bundle for character_anim_ctrl
interface character_anim_ctrl_if;
   logic        vblnk;
   logic [11:0] x_phys;
   logic [11:0] y_phys;
   logic        on_ground;
   logic        vel_y_neg;
   logic        charging;
   logic        moving;
   logic        face_left;
   logic [11:0] x_value;
   logic [11:0] y_value;
   logic [14:0] sprite_base;
   logic [2:0]  frame_idx;
   logic        mirror;
   logic        frame_tick;

   modport master (
      output vblnk, x_phys, y_phys, on_ground, vel_y_neg, charging, moving, face_left,
      input  x_value, y_value, sprite_base, frame_idx, mirror, frame_tick
   );

   modport slave (
      input  vblnk, x_phys, y_phys, on_ground, vel_y_neg, charging, moving, face_left,
      output x_value, y_value, sprite_base, frame_idx, mirror, frame_tick
   );
endinterface

// File: rtl/character_anim_ctrl.sv
// rtl/character_anim_ctrl.sv - frame-synchronous sprite frame sequencer; optional CHAR_MIRROR_EN
// Everything visible to the drawing stage is latched on the vblnk rising edge and held for a frame.
module character_anim_ctrl #(
   parameter int FRAME_WORDS = 3072,
   parameter int WALK_PERIOD = 8,
   parameter int LAND_HOLD   = 6,
   parameter int X_MAX       = 1023,
   parameter int Y_MAX       = 767
) (
   input  logic                  clk,
   input  logic                  rst,
   character_anim_ctrl_if.slave  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WALK_A = 3'd1;
   localparam logic [2:0] S_WALK_B = 3'd2;
   localparam logic [2:0] S_CROUCH = 3'd3;
   localparam logic [2:0] S_JUMP   = 3'd4;
   localparam logic [2:0] S_FALL   = 3'd5;
   localparam logic [2:0] S_LAND   = 3'd6;

   localparam logic [7:0]  WALK_LAST = 8'(WALK_PERIOD - 1);
   localparam logic [7:0]  LAND_LAST = 8'(LAND_HOLD - 1);
   localparam logic [11:0] X_LIM     = 12'(X_MAX);
   localparam logic [11:0] Y_LIM     = 12'(Y_MAX);
   localparam logic [14:0] FW        = 15'(FRAME_WORDS);

   logic        vblnk_q;
   logic        armed_q;
   logic        tick;
   logic        frame_tick_q;
   logic [2:0]  state_q, state_d;
   logic [7:0]  walk_cnt_q, walk_cnt_d;
   logic        walk_phase_q, walk_phase_d;
   logic [7:0]  land_cnt_q, land_cnt_d;
   logic [11:0] x_value_q, y_value_q;
   logic [14:0] sprite_base_q, sprite_base_d;
   logic        in_walk;

   // armed_q blocks a false edge when vblnk is already high as reset releases
   assign tick    = bus.vblnk & ~vblnk_q & armed_q;
   assign in_walk = (state_q == S_WALK_A) || (state_q == S_WALK_B);

   always_comb begin
      state_d      = state_q;
      walk_cnt_d   = walk_cnt_q;
      walk_phase_d = walk_phase_q;
      land_cnt_d   = land_cnt_q;
      if (tick) begin
         if (!bus.on_ground) begin
            state_d = bus.vel_y_neg ? S_JUMP : S_FALL;
         end else begin
            case (state_q)
               S_JUMP, S_FALL: begin
                  state_d    = S_LAND;
                  land_cnt_d = 8'd0;
               end
               S_LAND: begin
                  if (bus.charging) begin
                     state_d = S_CROUCH;
                  end else if (land_cnt_q == LAND_LAST) begin
                     state_d = bus.moving ? S_WALK_A : S_IDLE;
                  end else begin
                     land_cnt_d = land_cnt_q + 8'd1;
                  end
               end
               default: begin
                  if (bus.charging) begin
                     state_d = S_CROUCH;
                  end else if (bus.moving) begin
                     if (in_walk) begin
                        if (walk_cnt_q == WALK_LAST) begin
                           walk_cnt_d   = 8'd0;
                           walk_phase_d = ~walk_phase_q;
                        end else begin
                           walk_cnt_d = walk_cnt_q + 8'd1;
                        end
                     end
                     state_d = walk_phase_d ? S_WALK_B : S_WALK_A;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            endcase
            if ((state_d != S_WALK_A) && (state_d != S_WALK_B)) begin
               walk_cnt_d   = 8'd0;
               walk_phase_d = 1'b0;
            end
         end
      end
   end

   assign sprite_base_d = {12'd0, state_d} * FW;

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q       <= 1'b0;
         armed_q       <= 1'b0;
         frame_tick_q  <= 1'b0;
         state_q       <= S_IDLE;
         walk_cnt_q    <= 8'd0;
         walk_phase_q  <= 1'b0;
         land_cnt_q    <= 8'd0;
         x_value_q     <= 12'd0;
         y_value_q     <= 12'd0;
         sprite_base_q <= 15'd0;
      end else begin
         vblnk_q      <= bus.vblnk;
         frame_tick_q <= tick;
         state_q      <= state_d;
         walk_cnt_q   <= walk_cnt_d;
         walk_phase_q <= walk_phase_d;
         land_cnt_q   <= land_cnt_d;
         if (!bus.vblnk) begin
            armed_q <= 1'b1;
         end
         if (tick) begin
            x_value_q     <= (bus.x_phys > X_LIM) ? X_LIM : bus.x_phys;
            y_value_q     <= (bus.y_phys > Y_LIM) ? Y_LIM : bus.y_phys;
            sprite_base_q <= sprite_base_d;
         end
      end
   end

`ifdef CHAR_MIRROR_EN
   logic mirror_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mirror_q <= 1'b0;
      end else if (tick) begin
         mirror_q <= bus.face_left;
      end
   end

   assign bus.mirror = mirror_q;
`else
   assign bus.mirror = 1'b0;
`endif

   assign bus.x_value     = x_value_q;
   assign bus.y_value     = y_value_q;
   assign bus.sprite_base = sprite_base_q;
   assign bus.frame_idx   = state_q;
   assign bus.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_character_anim_ctrl.sv
// tb/tb_character_anim_ctrl.sv - randomized reference-model bench for character_anim_ctrl
module tb_character_anim_ctrl;

   localparam int FRAME_WORDS = 3072;
   localparam int WALK_PERIOD = 8;
   localparam int LAND_HOLD   = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;

   character_anim_ctrl_if bus ();

   character_anim_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int frame;
      int walk_n;
      int land_n;
   } mstate_t;

   mstate_t     m;
   logic        m_prev_v;
   logic [11:0] ex, ey;
   logic        em, et;

   // Walking frame is derived from how many consecutive walking ticks have elapsed.
   function automatic mstate_t model_next(mstate_t c, logic og, logic vn, logic ch, logic mv);
      mstate_t n = c;
      if (!og) begin
         n.frame  = vn ? 4 : 5;
         n.walk_n = -1;
      end else if (c.frame == 4 || c.frame == 5) begin
         n.frame  = 6;
         n.land_n = 0;
      end else if (c.frame == 6 && !ch && c.land_n + 1 < LAND_HOLD) begin
         n.land_n = c.land_n + 1;
      end else if (ch) begin
         n.frame  = 3;
         n.walk_n = -1;
      end else if (mv) begin
         n.walk_n = c.walk_n + 1;
         n.frame  = ((n.walk_n / WALK_PERIOD) % 2 == 1) ? 2 : 1;
      end else begin
         n.frame  = 0;
         n.walk_n = -1;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_prev_v <= 1'b1;
         m        <= '{frame: 0, walk_n: -1, land_n: 0};
         ex       <= '0;
         ey       <= '0;
         em       <= 1'b0;
         et       <= 1'b0;
      end else begin
         m_prev_v <= bus.vblnk;
         et       <= bus.vblnk && !m_prev_v;
         if (bus.vblnk && !m_prev_v) begin
            ex <= (bus.x_phys > 12'd1023) ? 12'd1023 : bus.x_phys;
            ey <= (bus.y_phys > 12'd767) ? 12'd767 : bus.y_phys;
            m  <= model_next(m, bus.on_ground, bus.vel_y_neg, bus.charging, bus.moving);
`ifdef CHAR_MIRROR_EN
            em <= bus.face_left;
`endif
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("x_value", 32'(bus.x_value), 32'(ex));
         chk("y_value", 32'(bus.y_value), 32'(ey));
         chk("frame_idx", 32'(bus.frame_idx), 32'(m.frame));
         chk("sprite_base", 32'(bus.sprite_base), 32'(m.frame * FRAME_WORDS));
         chk("mirror", 32'(bus.mirror), 32'(em));
         chk("frame_tick", 32'(bus.frame_tick), 32'(et));
      end
   end

   task automatic set_in(input logic og, input logic vn, input logic ch, input logic mv);
      bus.on_ground = og;
      bus.vel_y_neg = vn;
      bus.charging  = ch;
      bus.moving    = mv;
   endtask

   // Ends 3 time units after the edge that latched the tick.
   task automatic frame_step();
      @(posedge clk); #2 bus.vblnk = 1'b0;
      repeat (2) @(posedge clk);
      #2 bus.vblnk = 1'b1;
      @(posedge clk); #3;
   endtask

   task automatic rand_in();
      bus.x_phys    = 12'($urandom);
      bus.y_phys    = 12'($urandom);
      bus.face_left = 1'($urandom);
      if ($urandom_range(0, 5) == 0) bus.on_ground = ~bus.on_ground;
      if ($urandom_range(0, 3) == 0) bus.vel_y_neg = 1'($urandom);
      if ($urandom_range(0, 6) == 0) bus.charging  = ~bus.charging;
      if ($urandom_range(0, 12) == 0) bus.moving   = ~bus.moving;
   endtask

   initial begin
      bus.vblnk  = 1'b1;
      bus.x_phys = 12'd0;
      bus.y_phys = 12'd0;
      bus.face_left = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 chk_en = 1'b1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      chk("reset_frame", 32'(bus.frame_idx), 32'd0);
      chk("reset_base", 32'(bus.sprite_base), 32'd0);
      chk("reset_tick", 32'(bus.frame_tick), 32'd0);

      bus.x_phys = 12'd1500;
      bus.y_phys = 12'd900;
      frame_step();
      chk("first_tick", 32'(bus.frame_tick), 32'd1);
      chk("first_frame", 32'(bus.frame_idx), 32'd0);
      chk("clamp_x", 32'(bus.x_value), 32'd1023);
      chk("clamp_y", 32'(bus.y_value), 32'd767);
      bus.x_phys = 12'd5;
      repeat (2) @(posedge clk);
      #3;
      chk("x_hold", 32'(bus.x_value), 32'd1023);
      chk("tick_single", 32'(bus.frame_tick), 32'd0);

      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         frame_step();
         chk("walk_frame", 32'(bus.frame_idx), (((i - 1) / 8) % 2 == 1) ? 32'd2 : 32'd1);
         chk("walk_base", 32'(bus.sprite_base), (((i - 1) / 8) % 2 == 1) ? 32'd6144 : 32'd3072);
      end
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      frame_step();
      chk("walk_stop", 32'(bus.frame_idx), 32'd0);

      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      frame_step();
      chk("jump", 32'(bus.frame_idx), 32'd4);
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      frame_step();
      chk("fall", 32'(bus.frame_idx), 32'd5);
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         frame_step();
         chk("land_hold", 32'(bus.frame_idx), (k <= 6) ? 32'd6 : 32'd0);
      end

      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      frame_step();
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      frame_step();
      chk("land_entry", 32'(bus.frame_idx), 32'd6);
      set_in(1'b1, 1'b0, 1'b1, 1'b0);
      frame_step();
      chk("land_charge", 32'(bus.frame_idx), 32'd3);
      chk("crouch_base", 32'(bus.sprite_base), 32'd9216);

      bus.face_left = 1'b1;
      frame_step();
`ifdef CHAR_MIRROR_EN
      chk("mirror_on", 32'(bus.mirror), 32'd1);
`else
      chk("mirror_off", 32'(bus.mirror), 32'd0);
`endif

      @(posedge clk); #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      chk("midreset_frame", 32'(bus.frame_idx), 32'd0);
      chk("midreset_x", 32'(bus.x_value), 32'd0);
      chk("midreset_mirror", 32'(bus.mirror), 32'd0);
      #4 rst = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("no_tick_after_reset", 32'(bus.frame_tick), 32'd0);

      for (int f = 0; f < 250; f++) begin
         @(posedge clk); #2 bus.vblnk = 1'b0;
         rand_in();
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #2 rand_in();
         end
         bus.vblnk = 1'b1;
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #2 rand_in();
         end
         if ($urandom_range(0, 40) == 0) begin
            rst = 1'b1;
            bus.vblnk = 1'($urandom);
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #2 rst = 1'b0;
         end
      end

      repeat (3) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/character_anim_ctrl.md
Name: character_anim_ctrl

Overview:
- Frame-synchronous sequencer for the character sprite drawing stage.
- Takes the live physics state (position, ground contact, vertical velocity sign, jump charge, horizontal motion) and decides which sprite frame is drawn.
- Latches all values at the start of vertical blanking so the drawing stage sees stable values for a whole frame.
- Sits between the physics module and the sprite ROM / drawing stage; drives the ROM base offset and the x/y values consumed by the drawing stage.

Parameters:
- FRAME_WORDS, 3072, words per sprite frame in ROM (48 x 64)
- WALK_PERIOD, 8, display frames per walk-cycle frame toggle
- LAND_HOLD, 6, display frames the landing pose is held
- X_MAX, 1023, clamp limit for latched x
- Y_MAX, 767, clamp limit for latched y

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vblnk  in  1  vertical blanking from the timing chain
- x_phys  in  12  character x from physics
- y_phys  in  12  character y from physics
- on_ground  in  1  character standing on a platform
- vel_y_neg  in  1  vertical velocity upward (1) or downward/zero (0)
- charging  in  1  jump button held while grounded
- moving  in  1  horizontal walk input active
- face_left  in  1  facing direction from physics
- x_value  out  12  latched x for the drawing stage
- y_value  out  12  latched y for the drawing stage
- sprite_base  out  15  ROM base address of the selected frame = frame_idx * FRAME_WORDS
- frame_idx  out  3  selected sprite frame index
- mirror  out  1  horizontal flip request
- frame_tick  out  1  one-cycle pulse on each vblnk rising edge

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst. All outputs are registered.
- Reset values:
  - x_value=0, y_value=0, frame_idx=0, sprite_base=0, mirror=0, frame_tick=0
  - state=IDLE, walk_cnt=0, walk_phase=0, land_cnt=0, vblnk_d=0
- Frame tick:
  - vblnk_d registers vblnk.
  - tick = vblnk & ~vblnk_d.
  - frame_tick is tick delayed one cycle, aligned with the output update.
  - Outputs change only on the cycle after tick; they are constant between ticks.
- Position latch on tick:
  - x_value = min(x_phys, X_MAX).
  - y_value = min(y_phys, Y_MAX).
  - Unsigned compare; no wrap.
- FSM states and frame index: IDLE (0), WALK_A (1), WALK_B (2), CROUCH (3), JUMP (4), FALL (5), LAND (6). Index 7 is unused.
- FSM is evaluated only on tick. Priority, top down:
  - Any state, ~on_ground: JUMP if vel_y_neg, else FALL.
  - JUMP/FALL with on_ground: LAND, land_cnt=0.
  - LAND: stay until land_cnt==LAND_HOLD-1, incrementing each tick. Then go to CROUCH if charging, WALK_A if moving, else IDLE.
  - Grounded IDLE/WALK/CROUCH:
    - charging: CROUCH.
    - else moving: WALK_A or WALK_B per walk_phase.
    - else IDLE.
  - charging overrides LAND early: LAND with charging goes to CROUCH immediately.
- Walk counter:
  - Increments on each tick while in WALK_A/WALK_B.
  - At WALK_PERIOD-1 it wraps to 0 and toggles walk_phase.
  - Leaving WALK clears walk_cnt and walk_phase.
- Arithmetic: sprite_base is frame_idx * FRAME_WORDS in 15 bits. Max is 6*3072=18432, which fits. Registered in the same cycle as frame_idx.
- Simultaneous events:
  - Input changes between ticks are ignored; only values sampled on the tick cycle matter.
  - on_ground and charging both high in LAND: charging wins.
- Reset mid-frame: all outputs return to reset values on the next clock edge. The next update occurs on the first vblnk rising edge after rst deasserts. vblnk held high through reset does not generate a tick.

Optional Feature:
- Macro: CHAR_MIRROR_EN.
- Defined:
  - mirror latches face_left on each tick.
  - The drawing stage flips the column index.
- Undefined: mirror is tied to 0; face_left is unused.
- The FSM, timing and all other outputs are identical in both builds.

Test Plan:
- Reset, then vblnk held high: all outputs 0 and no frame_tick. After vblnk goes low then high, frame_tick pulses once and the state stays IDLE.
- x_phys=1500, y_phys=900 at tick: x_value=1023, y_value=767. Changing x_phys mid-frame leaves x_value unchanged until the next tick.
- Walk cycle: on_ground=1, moving=1 for 20 ticks.
  - frame_idx alternates 1 for 8 ticks, 2 for 8 ticks, then 1.
  - sprite_base alternates 3072/6144.
- Jump and land: on_ground=0 with vel_y_neg=1 gives frame 4; vel_y_neg=0 gives frame 5; on_ground=1 gives frame 6 for exactly 6 ticks, then frame 0.
- Charging during LAND on the second tick: frame goes to 3 on that tick; sprite_base=9216.
- CHAR_MIRROR_EN defined: face_left=1 gives mirror=1 after the next tick. Undefined: mirror stays 0 for face_left=1.
